// File: rtl/line_buf_ctrl_pkg.sv
// line_buf_ctrl_pkg: shared bank and controller state types for the line-buffer manager
package line_buf_ctrl_pkg;
  typedef enum logic [1:0] {BK_FREE, BK_FILL, BK_FULL} bank_state_t;
  typedef enum logic {LB_IDLE, LB_RUN} lb_state_t;
endpackage

// File: rtl/line_buf_ctrl_bank.sv
// line_buf_ctrl_bank: one row buffer with FREE/FILL/FULL tracking and min-fill flag
module line_buf_ctrl_bank
  import line_buf_ctrl_pkg::*;
#(
  parameter int XB = 10,
  parameter int PB = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_sel,
  input  logic          accept,
  input  logic          last_pix,
  input  logic          rel,
  input  logic          clear,
  input  logic [XB-1:0] wr_addr,
  input  logic [XB-1:0] minfill,
  input  logic [PB-1:0] wr_data,
  input  logic [XB-1:0] rd_addr,
  output logic [PB-1:0] rd_data,
  output logic          full,
  output logic          mf_flag
);
  logic [PB-1:0] mem [2**XB];
  bank_state_t st;
  logic we, freed, reached;
  assign we = wr_sel && accept;
  assign freed = rel && st == BK_FULL;
  assign reached = {1'b0, wr_addr} + (XB+1)'(1) >= {1'b0, minfill};
  assign full = st == BK_FULL;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
  // frame clear outranks a same-cycle release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= BK_FREE;
      mf_flag <= 1'b0;
    end else if (clear) begin
      st      <= BK_FREE;
      mf_flag <= 1'b0;
    end else begin
      st      <= freed ? BK_FREE : (we && last_pix) ? BK_FULL : (we && st == BK_FREE) ? BK_FILL : st;
      mf_flag <= freed ? 1'b0 : (we && (last_pix || reached)) ? 1'b1 : mf_flag;
    end
endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: streams pixels row-by-row into NM ring-ordered line banks with full/min-fill status
module line_buf_ctrl
  import line_buf_ctrl_pkg::*;
#(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NM = 4,
  localparam int BB = $clog2(NM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XB-1:0]          cfg_width,
  input  logic [YB-1:0]          cfg_height,
  input  logic [XB-1:0]          cfg_minfill,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [PB-1:0]          in_data,
  output logic                   in_ready,
  input  logic [NM-1:0]          mem_used,
  input  logic [NM-1:0][XB-1:0]  mb_rd_addr,
  output logic [NM-1:0][PB-1:0]  mem_data,
  output logic [NM-1:0]          mb_full,
  output logic [NM-1:0]          mb_minfill,
  output logic [BB-1:0]          wr_bank,
  output logic                   frame_done
);
  lb_state_t st;
  logic [XB-1:0] w, mf, col_cnt;
  logic [YB-1:0] h, row_cnt;
  logic acc, eol, eof, zero_cfg;
  assign in_ready = st == LB_RUN && !mb_full[wr_bank];
  assign acc = in_valid && in_ready && !frame_start;
  assign eol = col_cnt == w - XB'(1);
  assign eof = eol && row_cnt == h - YB'(1);
  assign zero_cfg = cfg_width == '0 || cfg_height == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st         <= LB_IDLE;
      w          <= '0;
      h          <= '0;
      mf         <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      wr_bank    <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      st         <= zero_cfg ? LB_IDLE : LB_RUN;
      w          <= cfg_width;
      h          <= cfg_height;
      mf         <= cfg_minfill == '0 ? XB'(1) : cfg_minfill;
      col_cnt    <= '0;
      row_cnt    <= '0;
      wr_bank    <= '0;
      frame_done <= zero_cfg;
    end else begin
      frame_done <= acc && eof;
      if (acc) begin
        col_cnt <= eol ? '0 : col_cnt + XB'(1);
        if (eol) row_cnt <= eof ? '0 : row_cnt + YB'(1);
        if (eol) wr_bank <= wr_bank == BB'(NM-1) ? '0 : wr_bank + BB'(1);
        if (eof) st <= LB_IDLE;
      end
    end
  for (genvar i = 0; i < NM; i++) begin : g_bank
    line_buf_ctrl_bank #(.XB(XB), .PB(PB)) u_bank (
      .clk(clk), .rst(rst),
      .wr_sel(wr_bank == BB'(i)), .accept(acc), .last_pix(eol),
      .rel(mem_used[i]), .clear(frame_start),
      .wr_addr(col_cnt), .minfill(mf), .wr_data(in_data),
      .rd_addr(mb_rd_addr[i]), .rd_data(mem_data[i]),
      .full(mb_full[i]), .mf_flag(mb_minfill[i])
    );
  end
endmodule
